// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Single-operation iterative multiply/divide unit (radix-2,
//               one bit per cycle) with a valid/ready request/result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int                c_cnt_w    = $clog2(XLEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
    localparam logic [XLEN-1:0]    c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2:0]          r_op;
    logic [TAG_W-1:0]    r_tag;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_mcand;
    logic                r_neg_q;
    logic                r_neg_r;

    // Request decode: operands are reduced to magnitudes, signs kept aside
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_bypass;
    logic [XLEN-1:0]     w_bypass_res;
    logic                w_accept;

    always_comb begin
        w_is_div     = in_op[2];
        w_a_signed   = w_is_div ? ~in_op[0] : (in_op == 3'd1 || in_op == 3'd2);
        w_b_signed   = w_is_div ? ~in_op[0] : (in_op == 3'd1);
        w_a_neg      = w_a_signed & in_a[XLEN-1];
        w_b_neg      = w_b_signed & in_b[XLEN-1];
        w_a_mag      = w_a_neg ? (~in_a + 1'b1) : in_a;
        w_b_mag      = w_b_neg ? (~in_b + 1'b1) : in_b;
        w_div_zero   = w_is_div && (in_b == '0);
        w_div_ovf    = w_is_div && ~in_op[0] && (in_a == c_int_min) && (in_b == '1);
        w_bypass     = w_div_zero | w_div_ovf;
        w_bypass_res = '0;
        if (w_div_zero) begin
            w_bypass_res = in_op[1] ? in_a : '1;
        end else if (w_div_ovf) begin
            w_bypass_res = in_op[1] ? '0 : in_a;
        end
        w_accept     = in_valid && (r_state == ST_IDLE) && ~flush;
    end

    // One iteration: shift-add for multiply, restoring step for divide
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic [XLEN-1:0]     w_hi_nxt;
    logic [XLEN-1:0]     w_lo_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;
    logic                w_last_iter;

    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_mcand};
        if (r_op[2]) begin
            w_hi_nxt = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
            w_hi_nxt = w_sum[XLEN:1];
            w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
        w_quo    = r_neg_q ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
        w_rem    = r_neg_r ? (~w_hi_nxt + 1'b1) : w_hi_nxt;
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quo;
        end else begin
            w_final = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
        end
        w_last_iter = (r_state == ST_BUSY) && (r_cnt == c_cnt_last);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_bypass ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (flush)            w_state_nxt = ST_IDLE;
                else if (w_last_iter) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (flush || out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op    <= in_op;
                r_tag   <= in_tag;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                r_mcand <= w_is_div ? w_b_mag : w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                if (w_bypass) r_result <= w_bypass_res;
            end else if (r_state == ST_BUSY && !flush) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (w_last_iter) r_result <= w_final;
            end
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign out_result = r_result;
    assign out_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking scoreboard bench for muldiv_unit (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int n_cmp = 0;
    int n_err = 0;

    logic [TAG_W+XLEN-1:0] q_exp[$];
    int                    q_lat[$];

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on 64-bit products and native SV division
    function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 1;
    endfunction

    // Drives one request, pushes its expectation, waits (bounded) for out_valid.
    // lat counts rising edges with the accepting edge as edge 1; -1 on timeout.
    task automatic send_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat,
                           input bit consume,
                           output logic [31:0] res, output logic [4:0] otag, output int lat);
        q_exp.push_back({tag, exp_res});
        q_lat.push_back(exp_lat);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (out_valid === 1'b1) begin lat = i; break; end
            @(negedge clk);
        end
        res  = out_result;
        otag = out_tag;
        if (consume && lat > 0) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++; $display("FAIL reset_handshake got ready/valid=%b want 10", {in_ready, out_valid});
        end
        n_cmp++;
        if ({out_tag, out_result} !== '0) begin
            n_err++; $display("FAIL reset_outputs got tag=%h result=%h want 0/0", out_tag, out_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed(input string name, input int first, input int cnt);
        logic [2:0]  ops  [12];
        logic [31:0] as   [12];
        logic [31:0] bs   [12];
        logic [31:0] exps [12];
        int          lats [12];
        logic [31:0] res;
        logic [4:0]  otag;
        logic [36:0] e;
        int          lat;
        int          el;
        ops[0]  = 3'd0; as[0]  = 32'd7;          bs[0]  = 32'hFFFF_FFFD; exps[0]  = 32'hFFFF_FFEB; lats[0]  = 33;
        ops[1]  = 3'd1; as[1]  = 32'h8000_0000;  bs[1]  = 32'h8000_0000; exps[1]  = 32'h4000_0000; lats[1]  = 33;
        ops[2]  = 3'd3; as[2]  = 32'hFFFF_FFFF;  bs[2]  = 32'hFFFF_FFFF; exps[2]  = 32'hFFFF_FFFE; lats[2]  = 33;
        ops[3]  = 3'd2; as[3]  = 32'hFFFF_FFFF;  bs[3]  = 32'hFFFF_FFFF; exps[3]  = 32'hFFFF_FFFF; lats[3]  = 33;
        ops[4]  = 3'd4; as[4]  = 32'hFFFF_FFF9;  bs[4]  = 32'd2;         exps[4]  = 32'hFFFF_FFFD; lats[4]  = 33;
        ops[5]  = 3'd6; as[5]  = 32'hFFFF_FFF9;  bs[5]  = 32'd2;         exps[5]  = 32'hFFFF_FFFF; lats[5]  = 33;
        ops[6]  = 3'd5; as[6]  = 32'd100;        bs[6]  = 32'd7;         exps[6]  = 32'd14;        lats[6]  = 33;
        ops[7]  = 3'd7; as[7]  = 32'd100;        bs[7]  = 32'd7;         exps[7]  = 32'd2;         lats[7]  = 33;
        ops[8]  = 3'd5; as[8]  = 32'd5;          bs[8]  = 32'd0;         exps[8]  = 32'hFFFF_FFFF; lats[8]  = 1;
        ops[9]  = 3'd6; as[9]  = 32'd5;          bs[9]  = 32'd0;         exps[9]  = 32'd5;         lats[9]  = 1;
        ops[10] = 3'd4; as[10] = 32'h8000_0000;  bs[10] = 32'hFFFF_FFFF; exps[10] = 32'h8000_0000; lats[10] = 1;
        ops[11] = 3'd6; as[11] = 32'h8000_0000;  bs[11] = 32'hFFFF_FFFF; exps[11] = 32'h0;         lats[11] = 1;
        for (int i = first; i < first + cnt; i++) begin
            send_op(ops[i], as[i], bs[i], 5'(i + 3), exps[i], lats[i], 1'b1, res, otag, lat);
            e  = q_exp.pop_front();
            el = q_lat.pop_front();
            n_cmp++;
            if (res !== e[31:0]) begin
                n_err++; $display("FAIL %s[%0d] result got %h want %h", name, i, res, e[31:0]);
            end
            n_cmp++;
            if (otag !== e[36:32]) begin
                n_err++; $display("FAIL %s[%0d] tag got %0d want %0d", name, i, otag, e[36:32]);
            end
            n_cmp++;
            if (lat != el) begin
                n_err++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, el);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  otag;
        logic [36:0] e;
        int          lat;
        int          el;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 1) ? 32'd0 : $urandom;
            if (i % 5 == 2) b = 32'($urandom_range(1, 300));
            if (i == 7) begin op = 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (i == 9) begin op = 3'd5; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            send_op(op, a, b, 5'($urandom), model_res(op, a, b), model_lat(op, a, b), 1'b1, res, otag, lat);
            e  = q_exp.pop_front();
            el = q_lat.pop_front();
            n_cmp++;
            if ({otag, res} !== e || lat != el) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got tag=%0d res=%h lat=%0d want tag=%0d res=%h lat=%0d",
                         i, op, a, b, otag, res, lat, e[36:32], e[31:0], el);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic [4:0]  otag;
        logic [36:0] e;
        int          lat;
        int          el;
        send_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, model_res(3'd3, 32'h1234_5678, 32'h9ABC_DEF0),
                33, 1'b0, res, otag, lat);
        e  = q_exp.pop_front();
        el = q_lat.pop_front();
        n_cmp++;
        if ({otag, res} !== e || lat != el) begin
            n_err++; $display("FAIL bp_first got tag=%0d res=%h lat=%0d want tag=%0d res=%h lat=%0d",
                              otag, res, lat, e[36:32], e[31:0], el);
        end
        in_valid = 1'b1; in_op = 3'd0; in_a = 32'd1; in_b = 32'd1; in_tag = 5'd1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, in_ready, out_tag, out_result} !== {1'b1, 1'b0, e}) begin
                n_err++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b tag=%0d res=%h want 1/0/%0d/%h",
                                  c, out_valid, in_ready, out_tag, out_result, e[36:32], e[31:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_release got valid/ready=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  otag;
        logic [36:0] e;
        int          lat;
        int          el;
        send_op(3'd0, 32'd3, 32'd5, 5'd1, 32'd15, 33, 1'b0, res, otag, lat);
        e  = q_exp.pop_front();
        el = q_lat.pop_front();
        n_cmp++;
        if ({otag, res} !== e || lat != el) begin
            n_err++; $display("FAIL b2b_first got tag=%0d res=%h lat=%0d want tag=%0d res=%h lat=%0d",
                              otag, res, lat, e[36:32], e[31:0], el);
        end
        q_exp.push_back({5'd9, 32'd1});
        q_lat.push_back(33);
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd3; in_a = 32'hFFFF_FFFF; in_b = 32'd2; in_tag = 5'd9;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL b2b_not_accepted got valid/ready=%b want 01", {out_valid, in_ready});
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            if (out_valid === 1'b1) begin lat = i; break; end
            @(negedge clk);
        end
        e  = q_exp.pop_front();
        el = q_lat.pop_front();
        n_cmp++;
        if ({out_tag, out_result} !== e || lat != el) begin
            n_err++; $display("FAIL b2b_second got tag=%0d res=%h lat=%0d want tag=%0d res=%h lat=%0d",
                              out_tag, out_result, lat, e[36:32], e[31:0], el);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        logic [31:0] res;
        logic [4:0]  otag;
        logic [36:0] e;
        int          lat;
        int          el;
        int          seen;
        // flush while idle must block acceptance
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd2;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_idle in_ready got %b want 1", in_ready);
        end
        // flush in the 12th busy cycle
        in_valid = 1'b1; in_tag = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL flush_busy got valid/ready=%b want 01", {out_valid, in_ready});
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen);
        end
        // reset in the 20th busy cycle
        in_valid = 1'b1; in_op = 3'd1; in_a = 32'hDEAD_BEEF; in_b = 32'h1357_9BDF; in_tag = 5'd17;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, out_tag, out_result} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin
            n_err++; $display("FAIL reset_mid got ready=%b valid=%b tag=%0d res=%h want 1/0/0/0",
                              in_ready, out_valid, out_tag, out_result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL reset_no_result got %0d valid cycles want 0", seen);
        end
        send_op(3'd0, 32'd6, 32'd7, 5'd11, 32'd42, 33, 1'b1, res, otag, lat);
        e  = q_exp.pop_front();
        el = q_lat.pop_front();
        n_cmp++;
        if ({otag, res} !== e || lat != el) begin
            n_err++; $display("FAIL reset_new_mul got tag=%0d res=%h lat=%0d want tag=%0d res=%h lat=%0d",
                              otag, res, lat, e[36:32], e[31:0], el);
        end
    endtask

    initial begin
        test_reset();
        test_directed("mul", 0, 4);
        test_directed("div", 4, 4);
        test_directed("bypass", 8, 4);
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; SHALL be an even value of at least 8.
REQ-002 Parameter TAG_W, default 5, width of the opaque tag (destination register index) carried with each operation.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 in_op  input  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 in_a, in_b  input  XLEN  rs1 and rs2 operands.
REQ-009 in_tag  input  TAG_W  tag returned with the result.
REQ-010 flush  input  1  abort the in-flight operation.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  XLEN  result value.
REQ-014 out_tag  output  TAG_W  tag of the result.

Function
REQ-015 The unit SHALL hold at most one operation, using FSM states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL equal (state==IDLE); a request SHALL be accepted on an edge where in_valid && in_ready && !flush.
REQ-017 On acceptance, the unit SHALL latch in_op, in_a, in_b and in_tag; later changes on the inputs SHALL have no effect.
REQ-018 IDLE->BUSY on acceptance; BUSY SHALL last exactly XLEN cycles (radix-2 iteration, one bit per cycle); BUSY->DONE after the final iteration.
REQ-019 out_valid SHALL equal (state==DONE); out_valid SHALL rise XLEN+1 rising edges after the accepting edge.
REQ-020 DONE->IDLE on an edge with out_ready high; out_result and out_tag SHALL stay stable while out_valid && !out_ready.
REQ-021 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits of the 2*XLEN product.
REQ-022 Operand signedness for multiplies: MULH signed x signed; MULHSU signed in_a x unsigned in_b; MULHU unsigned x unsigned.
REQ-023 DIV and REM SHALL round the quotient toward zero; the remainder sign SHALL follow the dividend; DIVU and REMU SHALL be unsigned.
REQ-024 Divide-by-zero (in_b==0): the quotient SHALL be all ones and the remainder SHALL equal in_a; the unit SHALL skip BUSY and go IDLE->DONE, so out_valid rises 1 edge after acceptance.
REQ-025 Signed overflow (DIV/REM with in_a = most-negative value and in_b = -1): the quotient SHALL equal in_a and the remainder SHALL be 0; the unit SHALL use the same 1-cycle bypass.
REQ-026 flush high in BUSY or DONE SHALL return the unit to IDLE on the next edge, drop the result, and hold out_valid low from that edge onward.
REQ-027 flush high in IDLE SHALL block acceptance on that edge.
REQ-028 Simultaneous out_ready and in_valid in DONE: the result SHALL be consumed; the new request SHALL NOT be accepted until the following cycle, when in_ready is high.
REQ-029 The iteration counter SHALL be ceil(log2(XLEN+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-030 While rst_n is low, state SHALL be IDLE, out_valid 0, in_ready 1, out_result 0, out_tag 0, and all datapath registers and the counter 0.
REQ-031 A reset asserted mid-operation SHALL immediately discard the operation; after release, the first result produced SHALL come only from a newly accepted request.

Verification (XLEN=32)
REQ-032 MUL a=7, b=0xFFFFFFFD, tag=3 -> out_result=0xFFFFFFEB, out_tag=3, out_valid rises exactly 33 edges after acceptance.
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; each with out_valid 1 edge after acceptance.
REQ-036 Hold out_ready low 10 cycles in DONE -> out_result and out_tag stable and in_ready low for all 10 cycles; one out_ready pulse -> IDLE on the next edge.
REQ-037 flush at BUSY cycle 12 -> IDLE next edge and no out_valid; rst_n pulsed low at BUSY cycle 20 -> all outputs at reset values; a new MUL 6x7 after release -> 42.
